// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed 32-bit multiply/divide into hi/lo (in: clk, reset, start_mult, start_div, a, b; out: hi, lo, busy, done, divby0flag)
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        divby0flag
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, FIX} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] m;
  logic        is_div, neg_q, neg_r;
  logic [31:0] abs_a, abs_b;
  logic [32:0] sum, trial;
  logic [63:0] prod;
  always_comb begin
    abs_a = a[31] ? -a : a;
    abs_b = b[31] ? -b : b;
    sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m} : 33'd0);
    trial = acc[63:31] - {1'b0, m};
    prod  = neg_q ? -acc : acc;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      acc        <= 64'd0;
      m          <= 32'd0;
      is_div     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      divby0flag <= 1'b0;
    end else begin
      done       <= 1'b0;
      divby0flag <= 1'b0;
      case (state)
        IDLE: begin
          if (start_mult) begin
            acc    <= {32'd0, abs_b};
            m      <= abs_a;
            is_div <= 1'b0;
            neg_q  <= a[31] ^ b[31];
            neg_r  <= a[31];
            cnt    <= 5'd0;
            busy   <= 1'b1;
            state  <= MULT;
          end else if (start_div && b != 32'd0) begin
            acc    <= {32'd0, abs_a};
            m      <= abs_b;
            is_div <= 1'b1;
            neg_q  <= a[31] ^ b[31];
            neg_r  <= a[31];
            cnt    <= 5'd0;
            busy   <= 1'b1;
            state  <= DIV;
          end else if (start_div) begin
            divby0flag <= 1'b1;
          end
        end
        MULT: begin
          acc   <= {sum, acc[31:1]};
          cnt   <= cnt + 5'd1;
          state <= cnt == 5'd31 ? FIX : MULT;
        end
        DIV: begin
          acc   <= trial[32] ? {acc[62:0], 1'b0} : {trial[31:0], acc[30:0], 1'b1};
          cnt   <= cnt + 5'd1;
          state <= cnt == 5'd31 ? FIX : DIV;
        end
        FIX: begin
          hi    <= is_div ? (neg_r ? -acc[63:32] : acc[63:32]) : prod[63:32];
          lo    <= is_div ? (neg_q ? -acc[31:0] : acc[31:0]) : prod[31:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench for mult_div_unit against a plain-arithmetic model
module tb_mult_div_unit;
  logic        clk = 0, reset = 1, start_mult = 0, start_div = 0;
  logic [31:0] a = 0, b = 0;
  logic [31:0] hi, lo;
  logic        busy, done, divby0flag;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_hi = 0, exp_lo = 0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start_mult(start_mult), .start_div(start_div),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .divby0flag(divby0flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] model(input logic d, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (!d) return 64'(sx * sy);
    return {32'(sx % sy), 32'(sx / sy)};
  endfunction

  task automatic idle();
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
  endtask

  task automatic op(input logic d, input logic [31:0] x, input logic [31:0] y,
                    input int stray, input int rst_at);
    int edges = 0, busy_cnt = 0;
    logic flag_seen = 0, seen = 0;
    logic [63:0] r;
    r = model(d, x, y);
    start_mult = !d; start_div = d; a = x; b = y;
    @(posedge clk); #1;
    start_mult = 0; start_div = 0; a = $urandom; b = $urandom;
    chk("done_low_after_start", done, 0);
    while (!done && edges < 40) begin
      busy_cnt += int'(busy);
      flag_seen |= divby0flag;
      start_div = (edges == stray);
      if (edges == stray) b = 0;
      reset = (edges == rst_at);
      @(posedge clk); #1;
      edges++;
      start_div = 0;
      if (reset) begin
        reset = 0;
        break;
      end
    end
    if (rst_at >= 0) begin
      exp_hi = 0; exp_lo = 0;
      chk("rst_busy", busy, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      repeat (40) begin
        @(posedge clk); #1;
        seen |= done | busy;
      end
      chk("rst_no_done", seen, 0);
    end else begin
      exp_hi = r[63:32]; exp_lo = r[31:0];
      chk("latency", edges, 33);
      chk("busy_cycles", busy_cnt, 33);
      chk("busy_clear", busy, 0);
      chk("no_flag", flag_seen, 0);
      chk(d ? "div_hi" : "mul_hi", hi, exp_hi);
      chk(d ? "div_lo" : "mul_lo", lo, exp_lo);
    end
  endtask

  task automatic dz(input logic [31:0] x);
    logic seen = 0;
    start_div = 1; a = x; b = 0;
    @(posedge clk); #1;
    start_div = 0;
    chk("dz_flag", divby0flag, 1);
    chk("dz_busy", busy, 0);
    @(posedge clk); #1;
    chk("dz_flag_pulse", divby0flag, 0);
    repeat (35) begin
      @(posedge clk); #1;
      seen |= done | busy | divby0flag;
    end
    chk("dz_quiet", seen, 0);
    chk("dz_hi", hi, exp_hi);
    chk("dz_lo", lo, exp_lo);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hilo", {hi, lo}, 0);
    chk("reset_ctl", {busy, done, divby0flag}, 0);
    reset = 0;
    idle();
    op(0, 32'd7, 32'hFFFFFFFD, -1, -1); idle();
    chk("mul_7x-3", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    op(1, 32'hFFFFFFF9, 32'd2, -1, -1); idle();
    chk("div_-7/2", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    op(1, 32'h04445111, 32'h2000, -1, -1); idle();
    chk("preload", {hi, lo}, 64'h00001111_00002222);
    dz($urandom);
    op(0, 32'h80000000, 32'h80000000, -1, -1); idle();
    chk("mul_min_min", {hi, lo}, 64'h40000000_00000000);
    op(1, 32'h80000000, 32'hFFFFFFFF, -1, -1); idle();
    chk("div_min_neg1", {hi, lo}, 64'h00000000_80000000);
    op(0, $urandom, $urandom, 10, -1); idle();
    op(0, $urandom, $urandom, -1, 20);
    op(0, 32'd12345, 32'hFFFFFD5A, -1, -1);
    op(1, 32'd100, 32'd7, -1, -1); idle();
    chk("b2b_div", {hi, lo}, {32'd2, 32'd14});
    for (int i = 0; i < 24; i++) begin
      logic d;
      logic [31:0] x, y;
      d = 1'($urandom);
      x = $urandom;
      case ($urandom % 4)
        0: y = 0;
        1: y = $urandom_range(1, 15);
        2: y = -$urandom_range(1, 15);
        default: y = $urandom;
      endcase
      if ($urandom % 3 == 0) x = $urandom_range(0, 3) == 0 ? 32'h80000000 : -$urandom_range(0, 100);
      if (d && y == 0) dz(x);
      else op(d, x, y, -1, -1);
      if ($urandom % 2 == 1) idle();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
